edf_arbiter: RTL and testbench



---
 rtl/edf_arbiter.sv | 135 +++++++++++++
 tb/tb_edf_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edf_arbiter.sv
// Sequential earliest-deadline-first selector: scans one gateway line per cycle,
// publishes the earliest-deadline pending line at sweep end, and pulses a one-hot claim on accept.
module edf_arbiter #(
    parameter  int NrIrqs  = 8,
    parameter  int TsWidth = 64,
    localparam int IdWidth = $clog2(NrIrqs)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NrIrqs-1:0]                ip_i,
    input  logic [NrIrqs-1:0][TsWidth-1:0]   dl_i,
    output logic [NrIrqs-1:0]                claim_o,
    output logic                             irq_valid_o,
    output logic [IdWidth-1:0]               irq_id_o,
    output logic [TsWidth-1:0]               irq_dl_o,
    input  logic                             irq_ready_i
);

    typedef enum logic {
        ST_SCAN  = 1'b0,
        ST_CLAIM = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [IdWidth-1:0]   r_idx;
    logic                 r_cand_vld;
    logic [IdWidth-1:0]   r_cand_id;
    logic [TsWidth-1:0]   r_cand_dl;

    logic [NrIrqs-1:0]    r_claim;
    logic                 r_irq_valid;
    logic [IdWidth-1:0]   r_irq_id;
    logic [TsWidth-1:0]   r_irq_dl;

    logic                 w_handshake;
    logic                 w_sweep_end;
    logic                 w_take;
    logic                 w_fin_vld;
    logic [IdWidth-1:0]   w_fin_id;
    logic [TsWidth-1:0]   w_fin_dl;
    logic [IdWidth-1:0]   w_idx_nxt;
    logic [NrIrqs-1:0]    w_claim_onehot;

    // State register
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process evaluation order.
        if (rst_i) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: CLAIM always lasts exactly one cycle
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_SCAN:  if (w_handshake) w_state_nxt = ST_CLAIM;
            ST_CLAIM: w_state_nxt = ST_SCAN;
            default:  w_state_nxt = ST_SCAN;
        endcase
    end

    // Output/datapath decode: running minimum including the line under the pointer
    always_comb begin
        w_handshake    = (r_state == ST_SCAN) && r_irq_valid && irq_ready_i;
        w_sweep_end    = (r_idx == IdWidth'(NrIrqs - 1));
        w_take         = ip_i[r_idx] && (!r_cand_vld || (dl_i[r_idx] < r_cand_dl));
        w_fin_vld      = r_cand_vld;
        w_fin_id       = r_cand_id;
        w_fin_dl       = r_cand_dl;
        if (w_take) begin
            w_fin_vld = 1'b1;
            w_fin_id  = r_idx;
            w_fin_dl  = dl_i[r_idx];
        end
        w_idx_nxt      = w_sweep_end ? '0 : r_idx + IdWidth'(1);
        w_claim_onehot = NrIrqs'(1) << r_irq_id;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx       <= '0;
            r_cand_vld  <= 1'b0;
            r_cand_id   <= '0;
            r_cand_dl   <= '0;
            r_claim     <= '0;
            r_irq_valid <= 1'b0;
            r_irq_id    <= '0;
            r_irq_dl    <= '0;
        end else if (w_handshake) begin
            // Accept wins over a coinciding publish; the partial sweep is discarded
            r_claim     <= w_claim_onehot;
            r_irq_valid <= 1'b0;
            r_irq_id    <= '0;
            r_irq_dl    <= '0;
            r_idx       <= '0;
            r_cand_vld  <= 1'b0;
            r_cand_id   <= '0;
            r_cand_dl   <= '0;
        end else if (r_state == ST_CLAIM) begin
            r_claim     <= '0;
            r_idx       <= '0;
            r_cand_vld  <= 1'b0;
            r_cand_id   <= '0;
            r_cand_dl   <= '0;
        end else if (w_sweep_end) begin
            r_claim     <= '0;
            r_irq_valid <= w_fin_vld;
            r_irq_id    <= w_fin_id;
            r_irq_dl    <= w_fin_dl;
            r_idx       <= '0;
            r_cand_vld  <= 1'b0;
            r_cand_id   <= '0;
            r_cand_dl   <= '0;
        end else begin
            r_claim     <= '0;
            r_idx       <= w_idx_nxt;
            r_cand_vld  <= w_fin_vld;
            r_cand_id   <= w_fin_id;
            r_cand_dl   <= w_fin_dl;
        end
    end

    assign claim_o     = r_claim;
    assign irq_valid_o = r_irq_valid;
    assign irq_id_o    = r_irq_id;
    assign irq_dl_o    = r_irq_dl;

endmodule

// File: tb/tb_edf_arbiter.sv
// Bench for edf_arbiter: directed scenarios plus random traffic, every cycle compared
// against a sweep-snapshot reference model that picks the earliest deadline at sweep end.
module tb_edf_arbiter;

    localparam int N  = 8;
    localparam int TW = 64;
    localparam int IW = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           ip;
    logic [N-1:0][TW-1:0]   dl;
    logic                   ready;
    logic [N-1:0]           claim;
    logic                   valid;
    logic [IW-1:0]          id;
    logic [TW-1:0]          dlo;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remembers what each line looked like when it was visited
    bit             m_in_claim;
    int             m_pos;
    bit             m_seen_ip [N];
    logic [TW-1:0]  m_seen_dl [N];
    logic [N-1:0]   m_claim;
    logic           m_valid;
    logic [IW-1:0]  m_id;
    logic [TW-1:0]  m_dl;

    always #5 clk = ~clk;

    edf_arbiter #(.NrIrqs(N), .TsWidth(TW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ip_i        (ip),
        .dl_i        (dl),
        .claim_o     (claim),
        .irq_valid_o (valid),
        .irq_id_o    (id),
        .irq_dl_o    (dlo),
        .irq_ready_i (ready)
    );

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_seen();
        for (int i = 0; i < N; i++) begin
            m_seen_ip[i] = 1'b0;
            m_seen_dl[i] = '0;
        end
    endtask

    task automatic model_edge();
        bit found;
        int best;
        if (rst) begin
            m_in_claim = 1'b0; m_pos = 0; m_claim = '0;
            m_valid = 1'b0; m_id = '0; m_dl = '0;
            clear_seen();
        end else if (m_in_claim) begin
            m_in_claim = 1'b0; m_pos = 0; m_claim = '0;
            clear_seen();
        end else if (m_valid && ready) begin
            m_claim = '0;
            m_claim[m_id] = 1'b1;
            m_valid = 1'b0; m_id = '0; m_dl = '0;
            m_in_claim = 1'b1; m_pos = 0;
            clear_seen();
        end else begin
            m_claim = '0;
            m_seen_ip[m_pos] = ip[m_pos];
            m_seen_dl[m_pos] = dl[m_pos];
            if (m_pos == N - 1) begin
                found = 1'b0;
                best  = 0;
                for (int i = 0; i < N; i++) begin
                    if (m_seen_ip[i] && (!found || m_seen_dl[i] < m_seen_dl[best])) begin
                        found = 1'b1;
                        best  = i;
                    end
                end
                m_valid = found;
                m_id    = found ? IW'(best) : '0;
                m_dl    = found ? m_seen_dl[best] : '0;
                clear_seen();
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    // One clock: update the model at the edge, compare outputs 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("claim_o",     TW'(claim), TW'(m_claim));
        check("irq_valid_o", TW'(valid), TW'(m_valid));
        check("irq_id_o",    TW'(id),    TW'(m_id));
        check("irq_dl_o",    dlo,        m_dl);
        // Gateway bank: a claimed line drops its pending flag before the next sweep
        if (m_claim != '0) ip = ip & ~m_claim;
    endtask

    task automatic wait_pos(input int p);
        for (int k = 0; k < 2 * N && m_pos != p; k++) step();
        if (m_pos != p) begin
            n_fail++;
            $display("FAIL wait_pos: timed out at pos %0d wanting %0d", m_pos, p);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit reached;
        rst = 1'b1; ip = '0; dl = '0; ready = 1'b0;
        m_pos = 0; m_in_claim = 1'b0;
        step(); step();
        check("rst_valid", TW'(valid), 64'd0);
        rst = 1'b0;

        // Reset mid-sweep with all lines pending
        ip = 8'hFF;
        for (int i = 0; i < N; i++) dl[i] = TW'(1000 + 7 * i);
        for (int k = 0; k < 13; k++) step();
        check("pre_rst_valid", TW'(valid), 64'd1);
        check("pre_rst_id",    TW'(id),    64'd0);
        rst = 1'b1;
        step();
        check("rst1_valid", TW'(valid), 64'd0);
        check("rst1_dl",    dlo,        64'd0);
        step();
        check("rst2_claim", TW'(claim), 64'd0);
        check("rst2_id",    TW'(id),    64'd0);
        rst = 1'b0;

        // Nothing pending for three sweeps, ready held high
        ip = '0; ready = 1'b1;
        for (int k = 0; k < 3 * N; k++) begin
            step();
            check("idle_valid", TW'(valid), 64'd0);
            check("idle_claim", TW'(claim), 64'd0);
        end
        ready = 1'b0;

        // Single line raised in the idx=0 cycle
        wait_pos(0);
        ip = 8'h20; dl[5] = 64'd100;
        for (int k = 0; k < N - 1; k++) step();
        check("single_early", TW'(valid), 64'd0);
        step();
        check("single_valid", TW'(valid), 64'd1);
        check("single_id",    TW'(id),    64'd5);
        check("single_dl",    dlo,        64'd100);

        // Earliest deadline wins
        ip = 8'b0100_0010; dl[1] = 64'd500; dl[6] = 64'd200;
        wait_pos(0);
        for (int k = 0; k < N; k++) step();
        check("earliest_id", TW'(id), 64'd6);
        check("earliest_dl", dlo,     64'd200);

        // Claim of line 6, then line 1 takes over
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("claim_pulse", TW'(claim), 64'h40);
        check("claim_valid", TW'(valid), 64'd0);
        step();
        check("claim_drop", TW'(claim), 64'd0);
        for (int k = 0; k < N - 1; k++) step();
        check("claim_t9_valid", TW'(valid), 64'd0);
        step();
        check("claim_t10_valid", TW'(valid), 64'd1);
        check("claim_t10_id",    TW'(id),    64'd1);
        check("claim_t10_dl",    dlo,        64'd500);

        // Preemption by an earlier deadline while not accepted
        step(); step(); step();
        ip[7] = 1'b1; dl[7] = 64'd10;
        reached = 1'b0;
        for (int k = 0; k < 2 * N && !reached; k++) begin
            step();
            check("preempt_hold", TW'(valid), 64'd1);
            if (m_pos == 0) reached = 1'b1;
        end
        check("preempt_reached", TW'(reached), 64'd1);
        check("preempt_id", TW'(id), 64'd7);
        check("preempt_dl", dlo,     64'd10);

        // Tie keeps the lower index
        ip = 8'b0001_0100; dl[2] = 64'd300; dl[4] = 64'd300;
        wait_pos(0);
        for (int k = 0; k < N; k++) step();
        check("tie_id", TW'(id), 64'd2);
        check("tie_dl", dlo,     64'd300);

        // Handshake on the sweep-end cycle while a new earlier line appears
        wait_pos(N - 1);
        ip[3] = 1'b1; dl[3] = 64'd50; ready = 1'b1;
        step();
        ready = 1'b0;
        check("se_claim", TW'(claim), 64'h04);
        check("se_valid", TW'(valid), 64'd0);
        for (int k = 0; k < N; k++) begin
            step();
            check("se_wait_valid", TW'(valid), 64'd0);
        end
        step();
        check("se_new_valid", TW'(valid), 64'd1);
        check("se_new_id",    TW'(id),    64'd3);
        check("se_new_dl",    dlo,        64'd50);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) ip = N'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 1) == 1)
                        dl[i] = TW'($urandom_range(0, 15));
                    else
                        dl[i] = {$urandom, $urandom};
                end
            end
            ready = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
